// File: rtl/avalon_pio_out_pulse.sv
// Avalon-MM output PIO: DATA/SET/CLR/TOGGLE registers plus a self-timed PULSE overlay.
// Ports: clk, reset (async, active-high), address/chipselect/write_n/writedata (slave write),
//   readdata (combinational, zero-extended), out_port = data_out | pulse_mask, irq (pulse done).
// Build option: define PIO_PULSE_IRQ_EN to add the W1C pulse-done event register and irq.
`timescale 1ns/1ps
module avalon_pio_out_pulse #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    PULSE_LEN   = 1000,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  irq
);

    localparam int CW = $clog2(PULSE_LEN + 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } pstate_t;

    logic [DATA_WIDTH-1:0] data_out;
    logic [DATA_WIDTH-1:0] pulse_mask;
    logic [DATA_WIDTH-1:0] mask_nxt;
    logic [DATA_WIDTH-1:0] wd;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_nxt;
    pstate_t               pstate;
    logic                  wr;
    logic                  pulse_wr;
    logic                  last;
    logic                  expire;
    logic                  evt_rd;

    assign wd       = writedata[DATA_WIDTH-1:0];
    assign wr       = chipselect & ~write_n;
    assign pulse_wr = wr && (address == 3'd4) && (wd != '0);
    assign pstate   = (cnt != '0) ? ACTIVE : IDLE;
    assign last     = (cnt == CW'(1));
    // A retrigger in the final cycle wins over the expiry.
    assign expire   = last && !pulse_wr;
    assign out_port = data_out | pulse_mask;

    generate
        if (DATA_WIDTH < 32) begin : g_unused
            logic unused_hi;
            assign unused_hi = ^writedata[31:DATA_WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= RESET_VALUE;
        end else if (wr) begin
            case (address)
                3'd0:    data_out <= wd;
                3'd1:    data_out <= data_out | wd;
                3'd2:    data_out <= data_out & ~wd;
                3'd3:    data_out <= data_out ^ wd;
                default: data_out <= data_out;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            pulse_mask <= '0;
        end else begin
            cnt        <= cnt_nxt;
            pulse_mask <= mask_nxt;
        end
    end

    // Retrigger restarts the full duration; the mask is merged only if the
    // pulse would still be visible after this edge.
    always_comb begin
        cnt_nxt  = cnt;
        mask_nxt = pulse_mask;
        if (pulse_wr) begin
            cnt_nxt  = CW'(PULSE_LEN);
            mask_nxt = (pstate == IDLE || last) ? wd : (pulse_mask | wd);
        end else if (pstate == ACTIVE) begin
            cnt_nxt = cnt - CW'(1);
            if (last) begin
                mask_nxt = '0;
            end
        end
    end

`ifdef PIO_PULSE_IRQ_EN
    logic evt_q;

    // Set has priority over a coincident W1C clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt_q <= 1'b0;
        end else if (expire) begin
            evt_q <= 1'b1;
        end else if (wr && (address == 3'd6) && writedata[0]) begin
            evt_q <= 1'b0;
        end
    end

    assign irq    = evt_q;
    assign evt_rd = evt_q;
`else
    logic unused_expire;
    assign unused_expire = expire;
    assign irq           = 1'b0;
    assign evt_rd        = 1'b0;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            3'd0:    readdata = 32'(data_out);
            3'd4:    readdata = 32'(pulse_mask);
            3'd5:    readdata = {24'(cnt), 7'd0, (pstate == ACTIVE)};
            3'd6:    readdata = {31'd0, evt_rd};
            default: readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_avalon_pio_out_pulse.sv
// Testbench for avalon_pio_out_pulse: directed steps then random traffic
// checked against a time-based reference model.
`timescale 1ns/1ps
module tb_avalon_pio_out_pulse;

    localparam int PL = 4;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        irq;

    int total;
    int bad;

    // Model: e counts clock edges; the pulse mask is visible after edge k
    // while k < m_end.
    int          e;
    int          m_end;
    logic [7:0]  m_data;
    logic [7:0]  m_mask;
    bit          m_ev;

    avalon_pio_out_pulse #(
        .DATA_WIDTH (8),
        .PULSE_LEN  (PL),
        .RESET_VALUE(8'hA5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] vis_mask();
        return (e < m_end) ? m_mask : 8'h00;
    endfunction

    function automatic logic [31:0] exp_read(input logic [2:0] a);
        logic [23:0] c;
        c = (m_end > e) ? 24'(m_end - e) : 24'd0;
        case (a)
            3'd0:    return {24'd0, m_data};
            3'd4:    return {24'd0, vis_mask()};
            3'd5:    return {c, 7'd0, (c != 24'd0)};
            3'd6:    return {31'd0, m_ev};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_data = 8'hA5;
        m_mask = 8'h00;
        m_end  = 0;
        m_ev   = 1'b0;
    endtask

    task automatic apply(input bit w, input logic [2:0] a, input logic [31:0] d);
        logic [7:0] wd;
        bit pw;
        bit ex;
        wd = d[7:0];
        pw = w && (a == 3'd4) && (wd != 8'h00);
        ex = (m_end == e) && !pw;
        if (w) begin
            case (a)
                3'd0: m_data = wd;
                3'd1: m_data = m_data | wd;
                3'd2: m_data = m_data & ~wd;
                3'd3: m_data = m_data ^ wd;
                3'd4: if (pw) begin
                    m_mask = (m_end > e) ? (m_mask | wd) : wd;
                    m_end  = e + PL;
                end
                default: ;
            endcase
        end
`ifdef PIO_PULSE_IRQ_EN
        if (w && (a == 3'd6) && d[0]) m_ev = 1'b0;
        if (ex) m_ev = 1'b1;
`else
        if (ex) m_ev = 1'b0;
`endif
    endtask

    task automatic step(input bit cs, input bit wn, input logic [2:0] a, input logic [31:0] d);
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = d;
        @(posedge clk);
        e++;
        apply(cs && !wn, a, d);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = $urandom;
        chk("out_port", {24'd0, out_port}, {24'd0, m_data | vis_mask()});
        chk("irq", {31'd0, irq}, {31'd0, m_ev});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 3'(i), 32'hFF);
    endtask

    task automatic rd(input logic [2:0] a);
        address = a;
        #1;
        chk($sformatf("read@%0d", a), readdata, exp_read(a));
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_out_port", {24'd0, out_port}, 32'hA5);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rd(3'd5);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        e          = 0;
        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 32'd0;
        model_reset();
        #1;
        chk("rst_out_port", {24'd0, out_port}, 32'hA5);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rd(3'd0);
        rd(3'd5);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        step(1, 0, 0, 32'h3C);
        step(1, 0, 1, 32'h81);
        rd(3'd1);
        step(1, 0, 2, 32'h0C);
        rd(3'd2);
        step(1, 0, 3, 32'hFF);
        rd(3'd3);
        rd(3'd0);

        step(1, 0, 0, 32'h00);
        step(1, 0, 4, 32'h01);
        rd(3'd5);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 3'd4, 32'h0);
            rd(3'd5);
            rd(3'd4);
        end

        step(1, 0, 4, 32'h01);
        idle(1);
        step(1, 0, 4, 32'h02);
        rd(3'd4);
        rd(3'd5);
        idle(5);
        step(1, 0, 4, 32'h00);
        rd(3'd5);
        step(0, 0, 0, 32'hFF);
        step(1, 1, 0, 32'hFF);
        step(1, 0, 5, 32'hFF);
        step(1, 0, 7, 32'hFF);
        rd(3'd7);

        step(1, 0, 4, 32'h01);
        idle(3);
        step(1, 0, 4, 32'h04);
        rd(3'd4);
        rd(3'd6);
        idle(5);
        rd(3'd6);
        step(1, 0, 6, 32'h1);
        rd(3'd6);

        step(1, 0, 4, 32'h10);
        idle(3);
        step(1, 0, 6, 32'h1);
        rd(3'd6);
        idle(2);
        step(1, 0, 6, 32'h1);

        step(1, 0, 4, 32'h0F);
        idle(1);
        do_reset();
        idle(5);

        for (int i = 0; i < 400; i++) begin
            logic [2:0]  a;
            logic [31:0] d;
            bit          cs;
            bit          wn;
            a  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) a = 3'd4;
            d  = $urandom;
            if ($urandom_range(0, 3) == 0) d = 32'h1 << $urandom_range(0, 7);
            cs = ($urandom_range(0, 1) == 0);
            wn = ($urandom_range(0, 4) == 0);
            step(cs, wn, a, d);
            rd(3'($urandom_range(0, 7)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
